jtpang_objdma: RTL

- Sequencer for the sprite DMA path. On a CPU `dma_go` request it takes the CPU bus via `busrq`/`busak_n` and streams the object table out of VRAM through `dma_addr`/`dma_din`.
- Each byte is written into a double-buffered object line buffer.
- The buffer bank seen by the object renderer swaps at the first vertical blank that follows a completed copy.
- Sits between the CPU interface, the char VRAM DMA port and the object renderer.

---
 rtl/jtpang_pkg.sv | 25 ++
 rtl/jtpang_objdma_bank.sv | 36 +++
 rtl/jtpang_objdma.sv | 133 +++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
// Shared types and constants for the jtpang object DMA path.
// Used by jtpang_objdma and its bank sub-module.
package jtpang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COPY = 2'd2,
    ST_REL  = 2'd3
  } dma_st_t;

  // object table size in bytes
  localparam int OBJ_LEN  = 512;

  // object table start inside char VRAM
  localparam int OBJ_BASE = 0;

  function automatic logic rise(
    input logic cur,
    input logic last
  );
    return cur & ~last;
  endfunction

endpackage

// File: rtl/jtpang_objdma_bank.sv
// Object line buffer bank control: LVBL fall detector,
// swap request latch and the renderer read bank.
module jtpang_objdma_bank (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic LVBL,
  input  logic busy,
  input  logic swap_set,
  output logic rd_bank
);

  logic lvbl_l;
  logic swap_pend;
  logic vb_fall;

  assign vb_fall = lvbl_l & ~LVBL;

  // swap banks at the first blank after a finished copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_l    <= 1'b0;
      swap_pend <= 1'b0;
      rd_bank   <= 1'b0;
    end else if (cen) begin
      lvbl_l <= LVBL;
      if (swap_set) begin
        swap_pend <= 1'b1;
      end else if (vb_fall && swap_pend && !busy) begin
        rd_bank   <= ~rd_bank;
        swap_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtpang_objdma.sv
// Sprite DMA sequencer: grabs the CPU bus and streams the object
// table from VRAM into the object line buffer. Macro: JTPANG_OBJDMA_PENDING_EN
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int LEN = OBJ_LEN,
  parameter int AW  = 9
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [AW:0]   buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          rd_bank,
  output logic          busy
);

  localparam logic [AW:0] LAST = (AW+1)'(LEN);

  dma_st_t       st;
  logic [AW:0]   cnt;
  logic [AW-1:0] idx_m1;
  logic          rd_vld;
  logic          go_l;
  logic          go_edge;
  logic          pend;
  logic          swap_set;

  assign go_edge  = rise(dma_go, go_l);
  assign idx_m1   = cnt[AW-1:0] - AW'(1);
  assign swap_set = (st == ST_REL);

`ifdef JTPANG_OBJDMA_PENDING_EN
  // one-deep memory of requests seen while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (cen) begin
      if (busy && go_edge) begin
        pend <= 1'b1;
      end else if (st == ST_IDLE) begin
        pend <= 1'b0;
      end
    end
  end
`else
  assign pend = 1'b0;
`endif

  // bus handshake and overlapped read/write copy sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      go_l     <= 1'b0;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      rd_vld   <= 1'b0;
      dma_addr <= '0;
      buf_addr <= '0;
      buf_din  <= '0;
      buf_we   <= 1'b0;
    end else if (cen) begin
      go_l   <= dma_go;
      buf_we <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (go_edge || pend) begin
            st     <= ST_REQ;
            busrq  <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            rd_vld <= 1'b0;
          end
        end
        ST_REQ: begin
          if (!busak_n) begin
            st <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (busak_n) begin
            // bus lost: drop the read in flight, reissue it later
            rd_vld <= 1'b0;
            if (rd_vld) begin
              cnt <= cnt - (AW+1)'(1);
            end
          end else begin
            buf_we <= rd_vld;
            if (rd_vld) begin
              buf_addr <= {~rd_bank, idx_m1};
              buf_din  <= dma_din;
            end
            if (cnt < LAST) begin
              dma_addr <= AW'(OBJ_BASE) + cnt[AW-1:0];
              cnt      <= cnt + (AW+1)'(1);
              rd_vld   <= 1'b1;
            end else begin
              rd_vld <= 1'b0;
              st     <= ST_REL;
            end
          end
        end
        ST_REL: begin
          busrq <= 1'b0;
          if (busak_n) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  jtpang_objdma_bank u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .LVBL     (LVBL),
    .busy     (busy),
    .swap_set (swap_set),
    .rd_bank  (rd_bank)
  );

endmodule
